// File: rtl/led_tube_pkg.sv
// Shared constants for the seven-segment scanner: active-low segment
// patterns (bit order g f e d c b a) and segment bit positions.
package led_tube_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam int unsigned SEG_BIT_A = 0;
    localparam int unsigned SEG_BIT_B = 1;
    localparam int unsigned SEG_BIT_C = 2;
    localparam int unsigned SEG_BIT_D = 3;
    localparam int unsigned SEG_BIT_E = 4;
    localparam int unsigned SEG_BIT_F = 5;
    localparam int unsigned SEG_BIT_G = 6;

endpackage

// File: rtl/led_tube_mux_seg7_decode.sv
// Combinational 4-bit code to active-low seven-segment pattern.
// Codes 10-15 show hex letters, or a dash when hex decoding is disabled.
module seg7_decode
    import led_tube_pkg::*;
(
    input  logic [3:0] i_code,
    input  logic       i_hex_en,
    output logic [6:0] o_pat
);

    // Pattern lookup for the selected digit code
    always_comb begin
        o_pat = SEG_BLANK;
        case (i_code)
            4'h0:    o_pat = SEG_0;
            4'h1:    o_pat = SEG_1;
            4'h2:    o_pat = SEG_2;
            4'h3:    o_pat = SEG_3;
            4'h4:    o_pat = SEG_4;
            4'h5:    o_pat = SEG_5;
            4'h6:    o_pat = SEG_6;
            4'h7:    o_pat = SEG_7;
            4'h8:    o_pat = SEG_8;
            4'h9:    o_pat = SEG_9;
            4'hA:    o_pat = i_hex_en ? SEG_A : SEG_DASH;
            4'hB:    o_pat = i_hex_en ? SEG_B : SEG_DASH;
            4'hC:    o_pat = i_hex_en ? SEG_C : SEG_DASH;
            4'hD:    o_pat = i_hex_en ? SEG_D : SEG_DASH;
            4'hE:    o_pat = i_hex_en ? SEG_E : SEG_DASH;
            4'hF:    o_pat = i_hex_en ? SEG_F : SEG_DASH;
            default: o_pat = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/led_tube_mux.sv
// Time-multiplexed N-digit seven-segment driver with shadowed frame loading,
// leading-zero blanking and 16-level PWM brightness; all outputs registered.
module led_tube_mux
    import led_tube_pkg::*;
#(
    parameter int unsigned NUM_DIGITS      = 4,
    parameter int unsigned DIV_WIDTH       = 8,
    parameter bit          HEX_EN          = 1'b1,
    parameter bit          SEG_ACTIVE_LOW  = 1'b1,
    parameter bit          WEI_ACTIVE_HIGH = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   data,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      load,
    input  logic                      blank_lz,
    input  logic [3:0]                bright,
    output logic [NUM_DIGITS-1:0]     wei,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic                      frame_done
);

    localparam logic [2:0]            LAST_IDX = 3'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] WEI_OFF  = WEI_ACTIVE_HIGH ? '0 : '1;
    localparam logic [6:0]            SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF   = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;

    logic [DIV_WIDTH-1:0]    r_presc;
    logic [2:0]              r_idx;
    logic                    r_pend;
    logic [4*NUM_DIGITS-1:0] r_sh_data;
    logic [NUM_DIGITS-1:0]   r_sh_dp;
    logic                    r_sh_blz;
    logic [NUM_DIGITS-1:0]   r_wei;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic                    r_frame_done;

    logic                    w_wrap;
    logic                    w_boundary;
    logic [3:0]              w_code;
    logic                    w_dp_sel;
    logic                    w_lz_sel;
    logic                    w_zero_run;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic [6:0]              w_dec;
    logic [6:0]              w_pat;
    logic                    w_on;

    assign w_wrap     = &r_presc;
    assign w_boundary = w_wrap && (r_idx == LAST_IDX);
    assign w_on       = (r_presc[DIV_WIDTH-1 -: 4] <= bright);

    // Select the current digit and evaluate the leading-zero run from the top digit down
    always_comb begin
        w_code     = 4'd0;
        w_dp_sel   = 1'b0;
        w_lz_sel   = 1'b0;
        w_onehot   = '0;
        w_zero_run = r_sh_blz;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zero_run = w_zero_run && (r_sh_data[4*i +: 4] == 4'd0);
            if (r_idx == 3'(i)) begin
                w_code      = r_sh_data[4*i +: 4];
                w_dp_sel    = r_sh_dp[i];
                w_lz_sel    = w_zero_run && (i != 0);
                w_onehot[i] = 1'b1;
            end else begin
                w_onehot[i] = 1'b0;
            end
        end
    end

    seg7_decode u_decode (
        .i_code   (w_code),
        .i_hex_en (HEX_EN),
        .o_pat    (w_dec)
    );

    // Blank when PWM-off or suppressed as a leading zero
    always_comb begin
        if (!w_on || w_lz_sel) begin
            w_pat = SEG_BLANK;
        end else begin
            w_pat = w_dec;
        end
    end

    // Scan timing, load handshake and shadow frame registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc      <= '0;
            r_idx        <= 3'd0;
            r_pend       <= 1'b0;
            r_sh_data    <= '0;
            r_sh_dp      <= '0;
            r_sh_blz     <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_presc      <= r_presc + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
            r_frame_done <= w_boundary;
            if (w_wrap) begin
                r_idx <= (r_idx == LAST_IDX) ? 3'd0 : r_idx + 3'd1;
            end else begin
                r_idx <= r_idx;
            end
            // A load in the boundary cycle itself is captured immediately
            if (w_boundary) begin
                r_pend <= 1'b0;
                if (r_pend || load) begin
                    r_sh_data <= data;
                    r_sh_dp   <= dp_in;
                    r_sh_blz  <= blank_lz;
                end else begin
                    r_sh_data <= r_sh_data;
                    r_sh_dp   <= r_sh_dp;
                    r_sh_blz  <= r_sh_blz;
                end
            end else begin
                r_pend <= r_pend || load;
            end
        end
    end

    // Registered pin drivers with polarity applied
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wei <= WEI_OFF;
            r_seg <= SEG_OFF;
            r_dp  <= DP_OFF;
        end else begin
            if (w_on) begin
                r_wei <= WEI_ACTIVE_HIGH ? w_onehot : ~w_onehot;
            end else begin
                r_wei <= WEI_OFF;
            end
            r_seg <= SEG_ACTIVE_LOW ? w_pat : ~w_pat;
            r_dp  <= (w_on && w_dp_sel) ? ~DP_OFF : DP_OFF;
        end
    end

    assign wei        = r_wei;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_done = r_frame_done;

endmodule

// File: doc/led_tube_mux.md
Name: led_tube_mux

Overview:
Parametrised, time-multiplexed N-digit seven-segment driver with decimal points, hex or decimal decode, leading-zero blanking, tear-free frame loading and 16-level PWM brightness.
- Sits between datapath and the board display pins.
- Replaces the fixed 4-digit, 10-bit-divider scanner.
- A single instance drives any digit count from 1 to 8.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
DIV_WIDTH, 8, prescaler width; each digit slot lasts 2^DIV_WIDTH clk cycles (minimum 4)
HEX_EN, 1, 1: codes 10-15 decode to A b C d E F; 0: codes 10-15 decode to dash (segment g only)
SEG_ACTIVE_LOW, 1, 1: seg/dp driven low = lit; 0: inverted
WEI_ACTIVE_HIGH, 1, 1: selected digit enable = 1; 0: inverted

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
data  in  4*NUM_DIGITS  digit codes; data[4i+3:4i] is digit i; digit 0 is least significant
dp_in  in  NUM_DIGITS  decimal point request per digit
load  in  1  request to capture data/dp_in/blank_lz into shadow registers
blank_lz  in  1  enable leading-zero suppression
bright  in  4  brightness level, 0 = 1/16 duty, 15 = full duty
wei  out  NUM_DIGITS  digit enables (one-hot when active)
seg  out  7  segments, seg[6:0] = g f e d c b a
dp  out  1  decimal point segment
frame_done  out  1  one-cycle pulse at the end of each full scan

Behaviour:
- Reset (rst low, async): all internal state clears.
  - Outputs: wei inactive (all 0 if WEI_ACTIVE_HIGH), seg and dp unlit, frame_done 0.
  - Internal: prescaler 0, digit index 0, shadow data/dp/blank_lz 0, load pending 0.
- Prescaler: DIV_WIDTH-bit free-running up-counter; wraps 2^DIV_WIDTH-1 -> 0.
- Digit index:
  - Advances on each prescaler wrap.
  - Goes from NUM_DIGITS-1 to 0 (not modulo power of two).
  - On the NUM_DIGITS-1 -> 0 step ("frame boundary"), frame_done pulses high for exactly that cycle.
- Load:
  - A load pulse sets "pending".
  - At the next frame boundary the shadow registers capture the current data/dp_in/blank_lz and pending clears.
  - If load is high in the boundary cycle itself, capture happens in that cycle.
  - Multiple loads within one frame collapse to one capture of the values present at the boundary.
  - The display never shows a mixed frame.
- Decode (on shadow values), active-low polarity:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110
  - dash = 0111111, blank = 1111111
  - Invert all patterns when SEG_ACTIVE_LOW = 0.
- Leading-zero blanking:
  - Digit i (i >= 1) shows blank when shadow blank_lz = 1 and all shadow digits NUM_DIGITS-1..i equal 0.
  - Digit 0 is never blanked.
  - A blanked digit's dp is still driven from shadow dp.
- Brightness:
  - Let p = prescaler[DIV_WIDTH-1 : DIV_WIDTH-4].
  - The digit is enabled while p <= bright.
  - When disabled, wei is inactive and seg/dp are unlit.
  - bright is sampled live (not shadowed).
- Outputs are registered.
  - wei/seg/dp reflect the index/prescaler state of the previous cycle (1-cycle latency).
  - At most one wei bit is active at any time.
- NUM_DIGITS = 1: index stays 0; frame_done pulses on every prescaler wrap.

Decomposition:
- Package led_tube_pkg:
  - 7-bit segment pattern constants (SEG_0..SEG_F, SEG_DASH, SEG_BLANK).
  - Segment bit-index constants.
- Sub-module seg7_decode: combinational 4-bit code + hex_en -> 7-bit active-low pattern.
  - Instantiated once on the currently selected digit.
  - Polarity inversion is applied in the top level.

Test Plan:
- Reset then release (NUM_DIGITS=4, DIV_WIDTH=4, bright=15) -> wei steps 0001, 0010, 0100, 1000 every 16 cycles; frame_done pulses every 64 cycles; seg shows 1000000 for all digits after the first load of 0.
- data=0x1234, load once mid-frame -> old value shown until the frame boundary, then digit3..0 = 1111001, 0100100, 0110000, 0011001 with no mixed frame.
- data=0x00A5, HEX_EN=1, blank_lz=1 -> digits 3 and 2 blank (1111111), digit1 = 0001000, digit0 = 0010010; with HEX_EN=0, digit1 = 0111111.
- data=0x0000, blank_lz=1, dp_in=0100 -> digits 3..1 blank, digit0 = 1000000, dp lit only during digit 2.
- bright=0 -> each wei pulse lasts 1 of every 16 cycles in its slot; bright=7 -> 8 of 16 cycles.
- Assert rst low mid-slot with load pending -> outputs go unlit/inactive immediately (async); after release the scan restarts at digit 0 and the shadow holds 0.
